writeback: RTL

WRITEBACK -- requirements
Module: writeback

---
 rtl/y86_pkg.sv | 60 ++++++
 rtl/regfile.sv | 79 +++++++
 rtl/writeback.sv | 109 ++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// y86_pkg: shared definitions for the Y86-64 writeback slice.
//   - icode constants (IHALT..IPOPQ)
//   - status codes (SAOK, SHLT, SADR, SINS)
//   - register index names and RNONE
//   - wb_state enum used by the writeback state machine
//   - err_stat(): folds any non-AOK/non-HLT status into ADR or INS
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] ICMOVXX = 4'h2;   // rrmovq / cmovXX share this code
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // Status codes
    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    // Register indices
    localparam logic [3:0] RRAX  = 4'h0;
    localparam logic [3:0] RRCX  = 4'h1;
    localparam logic [3:0] RRDX  = 4'h2;
    localparam logic [3:0] RRBX  = 4'h3;
    localparam logic [3:0] RRSP  = 4'h4;
    localparam logic [3:0] RRBP  = 4'h5;
    localparam logic [3:0] RRSI  = 4'h6;
    localparam logic [3:0] RRDI  = 4'h7;
    localparam logic [3:0] RR8   = 4'h8;
    localparam logic [3:0] RR9   = 4'h9;
    localparam logic [3:0] RR10  = 4'hA;
    localparam logic [3:0] RR11  = 4'hB;
    localparam logic [3:0] RR12  = 4'hC;
    localparam logic [3:0] RR13  = 4'hD;
    localparam logic [3:0] RR14  = 4'hE;
    localparam logic [3:0] RNONE = 4'hF;

    localparam int NUM_REGS = 15;

    typedef enum logic [1:0] {
        WB_RUN  = 2'd0,
        WB_HALT = 2'd1,
        WB_ERR  = 2'd2
    } wb_state_e;

    // ADR stays ADR; INS and every unrecognised status become INS.
    function automatic logic [2:0] err_stat(input logic [2:0] s);
        return (s == SADR) ? SADR : SINS;
    endfunction

endpackage

// File: rtl/regfile.sv
// regfile: 15 x 64-bit register file, two write ports and two read ports.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset (clears all registers)
//   we_e/addr_e/data_e  write port E (execute result)
//   we_m/addr_m/data_m  write port M (memory result); wins over E on the same index
//   addr_a, addr_b    read addresses
//   rd_a, rd_b        read data; index RNONE always reads 0
//
// Build option:
//   WB_BYPASS_EN  when defined, a read whose address matches a write in progress
//                 returns the write data (M before E). Otherwise reads return the
//                 register contents as they were before the edge.
module regfile
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_e,
    input  logic [3:0]  addr_e,
    input  logic [63:0] data_e,
    input  logic        we_m,
    input  logic [3:0]  addr_m,
    input  logic [63:0] data_m,
    input  logic [3:0]  addr_a,
    input  logic [3:0]  addr_b,
    output logic [63:0] rd_a,
    output logic [63:0] rd_b
);

    logic [63:0] regs [0:NUM_REGS-1];

    logic wr_e;
    logic wr_m;

    // RNONE is filtered here so no write can ever land outside the array.
    assign wr_e = we_e && (addr_e != RNONE);
    assign wr_m = we_m && (addr_m != RNONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            // M is written last so it takes precedence when both ports hit
            // the same register (popq %rsp).
            if (wr_e) regs[addr_e] <= data_e;
            if (wr_m) regs[addr_m] <= data_m;
        end
    end

    always_comb begin
        rd_a = '0;
        if (addr_a != RNONE) begin
`ifdef WB_BYPASS_EN
            if (wr_m && (addr_m == addr_a))      rd_a = data_m;
            else if (wr_e && (addr_e == addr_a)) rd_a = data_e;
            else                                 rd_a = regs[addr_a];
`else
            rd_a = regs[addr_a];
`endif
        end
    end

    always_comb begin
        rd_b = '0;
        if (addr_b != RNONE) begin
`ifdef WB_BYPASS_EN
            if (wr_m && (addr_m == addr_b))      rd_b = data_m;
            else if (wr_e && (addr_e == addr_b)) rd_b = data_e;
            else                                 rd_b = regs[addr_b];
`else
            rd_b = regs[addr_b];
`endif
        end
    end

endmodule

// File: rtl/writeback.sv
// writeback: Y86-64 writeback stage. Commits retiring instructions into the
// register file, tracks architectural status and counts retired instructions.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   in_valid/in_ready handshake with the memory stage; transfer when both are 1
//   icode, cnd        instruction code and condition flag (cmovXX suppression)
//   stat              instruction status (AOK/HLT/ADR/INS, others treated as INS)
//   dstE/valE         execute destination and value (RNONE = no write)
//   dstM/valM         memory destination and value (RNONE = no write)
//   srcA/srcB         decode read addresses
//   rd_a/rd_b         decode read data
//   cpu_stat          architectural status
//   halted            1 whenever the state machine has left RUN
//   retired           64-bit count of committed instructions
//
// Build option:
//   WB_BYPASS_EN  same-cycle write-through on rd_a/rd_b (see regfile).
//
// State table:
//   state   | meaning
//   WB_RUN  | accepting instructions, in_ready=1
//   WB_HALT | halt retired; terminal until reset, everything frozen
//   WB_ERR  | ADR/INS fault; terminal until reset, everything frozen
module writeback
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  icode,
    input  logic        cnd,
    input  logic [2:0]  stat,
    input  logic [3:0]  dstE,
    input  logic [3:0]  dstM,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic [3:0]  srcA,
    input  logic [3:0]  srcB,
    output logic [63:0] rd_a,
    output logic [63:0] rd_b,
    output logic [2:0]  cpu_stat,
    output logic        halted,
    output logic [63:0] retired
);

    wb_state_e state;

    logic transfer;
    logic commit;
    logic cmov_skip;
    logic we_e;
    logic we_m;

    assign transfer  = in_valid && (state == WB_RUN);
    // Writes only happen for AOK transfers; reset takes priority over a
    // transfer on the same edge, so gating with rst_n also keeps the bypass
    // path from forwarding a discarded instruction.
    assign commit    = transfer && rst_n && (stat == SAOK);
    assign cmov_skip = (icode == ICMOVXX) && !cnd;
    assign we_e      = commit && !cmov_skip;
    assign we_m      = commit;

    regfile u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_e   (we_e),
        .addr_e (dstE),
        .data_e (valE),
        .we_m   (we_m),
        .addr_m (dstM),
        .data_m (valM),
        .addr_a (srcA),
        .addr_b (srcB),
        .rd_a   (rd_a),
        .rd_b   (rd_b)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= WB_RUN;
            cpu_stat <= SAOK;
            retired  <= '0;
            in_ready <= 1'b1;
            halted   <= 1'b0;
        end else if (transfer) begin
            case (stat)
                SAOK: begin
                    retired <= retired + 64'd1;
                end
                SHLT: begin
                    retired  <= retired + 64'd1;
                    state    <= WB_HALT;
                    cpu_stat <= SHLT;
                    in_ready <= 1'b0;
                    halted   <= 1'b1;
                end
                default: begin
                    state    <= WB_ERR;
                    cpu_stat <= err_stat(stat);
                    in_ready <= 1'b0;
                    halted   <= 1'b1;
                end
            endcase
        end
    end

endmodule
